// File: rtl/bp_sched.sv
// bp_sched: arbitrates the single-ported branch prediction table between Decode lookups and queued Execute updates.
// Optional feature macro BP_SCHED_BYPASS_EN: a lookup sees the youngest queued update to its index.
module bp_sched #(
  parameter int ENTRIES    = 256,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      lk_valid,
  input  logic [31:0]               lk_pc,
  output logic                      lk_ready,
  output logic                      pred_valid,
  output logic                      pred_taken,
  output logic [31:0]               pred_target,
  input  logic                      up_valid,
  input  logic [31:0]               up_pc,
  input  logic                      up_taken,
  input  logic [31:0]               up_target,
  output logic                      up_ready,
  output logic [$clog2(QDEPTH):0]   q_count
);

  // state  | meaning
  // IDLE   | serve lookups; start a drain when updates wait and no lookup is granted
  // UPD_RD | read the 2-bit state addressed by the FIFO head
  // UPD_WR | write the updated state (and target if taken), pop the FIFO

  localparam int IW = $clog2(ENTRIES);
  localparam int PW = $clog2(QDEPTH);
  localparam int QW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, UPD_RD, UPD_WR} state_t;

  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic [SW-1:0]   starve_inc;
  logic [1:0]      rd_st;

  logic [1:0]      tbl_st  [ENTRIES];
  logic [31:0]     tbl_tgt [ENTRIES];

  logic [IW-1:0]   f_idx [QDEPTH];
  logic            f_tk  [QDEPTH];
  logic [31:0]     f_tgt [QDEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  logic [IW-1:0]   lk_idx;
  logic            force_drain;
  logic            q_nonempty;
  logic            grant;
  logic            push;
  logic            pop;
  logic            drain_go;
  logic            lk_taken;
  logic [31:0]     lk_tgt;
  logic            unused_pc_bits;

  assign lk_idx         = lk_pc[IW+1:2];
  assign unused_pc_bits = ^{lk_pc[31:IW+2], lk_pc[1:0], up_pc[31:IW+2], up_pc[1:0]};

  assign q_nonempty  = (q_count != '0);
  assign force_drain = (q_count == QW'(QDEPTH)) | (starve_cnt == SMAX);
  assign lk_ready    = (state == IDLE) & ~force_drain;
  assign up_ready    = (q_count < QW'(QDEPTH));
  assign grant       = lk_valid & lk_ready;
  assign push        = up_valid & up_ready;
  assign pop         = (state == UPD_WR);

  always_comb begin
    starve_inc = starve_cnt;
    if (grant && q_nonempty && (starve_cnt != SMAX))
      starve_inc = starve_cnt + SW'(1);
  end

  // Drain starts on the same edge as the STARVE_MAX-th grant, so the stall is exactly UPD_RD + UPD_WR.
  assign drain_go = (state == IDLE) & (q_nonempty | push) & (~grant | (starve_inc == SMAX));

  always_comb begin
    lk_taken = tbl_st[lk_idx][1];
    lk_tgt   = tbl_tgt[lk_idx];
`ifdef BP_SCHED_BYPASS_EN
    for (int k = 0; k < QDEPTH; k++) begin
      logic [PW-1:0] slot;
      slot = rd_ptr + PW'(k);
      // walk oldest to youngest so the youngest match wins
      if ((QW'(k) < q_count) && (f_idx[slot] == lk_idx)) begin
        lk_taken = f_tk[slot];
        lk_tgt   = f_tk[slot] ? f_tgt[slot] : tbl_tgt[lk_idx];
      end
    end
`endif
  end

  function automatic logic [1:0] next_st(input logic [1:0] s, input logic tk);
    if (tk)
      return (s == 2'b00) ? 2'b01 : 2'b11;
    return (s == 2'b11) ? 2'b10 : 2'b00;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      rd_st       <= 2'b00;
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid <= 1'b0;
      if (drain_go || !q_nonempty)
        starve_cnt <= '0;
      else
        starve_cnt <= starve_inc;
      case (state)
        IDLE: begin
          if (grant) begin
            pred_valid  <= 1'b1;
            pred_taken  <= lk_taken;
            pred_target <= lk_tgt;
          end
          if (drain_go)
            state <= UPD_RD;
        end
        UPD_RD: begin
          rd_st <= tbl_st[f_idx[rd_ptr]];
          state <= UPD_WR;
        end
        UPD_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_st[i]  <= 2'b00;
        tbl_tgt[i] <= '0;
      end
    end else if (pop) begin
      tbl_st[f_idx[rd_ptr]] <= next_st(rd_st, f_tk[rd_ptr]);
      if (f_tk[rd_ptr])
        tbl_tgt[f_idx[rd_ptr]] <= f_tgt[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + QW'(1);
        2'b01:   q_count <= q_count - QW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Payload needs no reset: occupancy gates every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      f_idx[wr_ptr] <= up_pc[IW+1:2];
      f_tk[wr_ptr]  <= up_taken;
      f_tgt[wr_ptr] <= up_target;
    end
  end

endmodule

// File: tb/tb_bp_sched.sv
// Bench for bp_sched: directed scenarios plus random traffic against a queue-based reference model.
module tb_bp_sched;

  localparam int ENT  = 256;
  localparam int QD   = 4;
  localparam int SMAX = 3;

  logic        clk;
  logic        rst_n;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        lk_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        up_valid;
  logic [31:0] up_pc;
  logic        up_taken;
  logic [31:0] up_target;
  logic        up_ready;
  logic [2:0]  q_count;

  bp_sched #(.ENTRIES(ENT), .QDEPTH(QD), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_ready(lk_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_target(up_target),
    .up_ready(up_ready), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: table as plain arrays, pending updates as a queue, phase 0=idle 1=read 2=write.
  typedef struct { int idx; bit tk; logic [31:0] tgt; } upd_t;
  upd_t        mq[$];
  int          m_st  [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_phase;
  int          m_starve;
  bit          m_pv;
  bit          m_pt;
  logic [31:0] m_ptg;
  int          nxt_t [4] = '{1, 3, 3, 3};
  int          nxt_n [4] = '{0, 0, 0, 2};

  function automatic void m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_st[i]  = 0;
      m_tgt[i] = '0;
    end
    mq.delete();
    m_phase  = 0;
    m_starve = 0;
    m_pv     = 0;
    m_pt     = 0;
    m_ptg    = '0;
  endfunction

  function automatic bit m_lk_ready();
    return (m_phase == 0) && (mq.size() < QD) && (m_starve != SMAX);
  endfunction

  task automatic m_step(input bit lkv, input logic [31:0] lkpc, input bit upv,
                        input logic [31:0] uppc, input bit upt, input logic [31:0] uptg);
    int   qn;
    int   li;
    int   ns;
    bit   grant;
    bit   push;
    bit   drain;
    bit   found;
    upd_t u;
    qn    = mq.size();
    grant = lkv && m_lk_ready();
    push  = upv && (qn < QD);
    li    = int'((lkpc >> 2) % ENT);
    m_pv  = grant;
    if (grant) begin
      m_pt  = (m_st[li] >= 2);
      m_ptg = m_tgt[li];
`ifdef BP_SCHED_BYPASS_EN
      found = 0;
      for (int k = qn - 1; k >= 0; k--) begin
        if (!found && mq[k].idx == li) begin
          found = 1;
          m_pt  = mq[k].tk;
          m_ptg = mq[k].tk ? mq[k].tgt : m_tgt[li];
        end
      end
`else
      found = 0;
`endif
    end
    ns = (grant && qn > 0 && m_starve < SMAX) ? m_starve + 1 : m_starve;
    drain = (m_phase == 0) && (qn > 0 || push) && (!grant || ns == SMAX);
    if (drain || qn == 0) m_starve = 0;
    else m_starve = ns;
    case (m_phase)
      0: if (drain) m_phase = 1;
      1: m_phase = 2;
      default: begin
        u = mq.pop_front();
        m_st[u.idx] = u.tk ? nxt_t[m_st[u.idx]] : nxt_n[m_st[u.idx]];
        if (u.tk) m_tgt[u.idx] = u.tgt;
        m_phase = 0;
      end
    endcase
    if (push) begin
      u.idx = int'((uppc >> 2) % ENT);
      u.tk  = upt;
      u.tgt = uptg;
      mq.push_back(u);
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance model, return at next posedge+1.
  task automatic cyc(input bit lkv, input logic [31:0] lkpc, input bit upv,
                     input logic [31:0] uppc, input bit upt, input logic [31:0] uptg);
    lk_valid  = lkv;
    lk_pc     = lkpc;
    up_valid  = upv;
    up_pc     = uppc;
    up_taken  = upt;
    up_target = uptg;
    @(negedge clk);
    chk("lk_ready",    32'(lk_ready),    32'(m_lk_ready()));
    chk("up_ready",    32'(up_ready),    32'(mq.size() < QD));
    chk("q_count",     32'(q_count),     32'(mq.size()));
    chk("pred_valid",  32'(pred_valid),  32'(m_pv));
    chk("pred_taken",  32'(pred_taken),  32'(m_pt));
    chk("pred_target", pred_target,      m_ptg);
    m_step(lkv, lkpc, upv, uppc, upt, uptg);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, 0, '0);
  endtask

  task automatic do_reset();
    lk_valid = 0; lk_pc = '0; up_valid = 0; up_pc = '0; up_taken = 0; up_target = '0;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_q_count",    32'(q_count),    32'd0);
    chk("rst_pred_valid", 32'(pred_valid), 32'd0);
    chk("rst_up_ready",   32'(up_ready),   32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          exp_r [6] = '{1, 1, 1, 0, 0, 1};
    int          exp_q [6] = '{1, 1, 1, 1, 1, 0};
    logic [31:0] r;
    logic [31:0] pc_l;
    logic [31:0] pc_u;
    rst_n = 1'b0;
    #3;
    do_reset();
    chk("rst_lk_ready",    32'(lk_ready),    32'd1);
    chk("rst_pred_taken",  32'(pred_taken),  32'd0);
    chk("rst_pred_target", pred_target,      32'd0);

    // cold lookup
    cyc(1, 32'h14, 0, '0, 0, '0);
    chk("cold_pv",  32'(pred_valid),  32'd1);
    chk("cold_pt",  32'(pred_taken),  32'd0);
    chk("cold_ptg", pred_target,      32'd0);
    cyc(0, '0, 0, '0, 0, '0);
    chk("pv_drop",  32'(pred_valid),  32'd0);

    // two taken updates -> state 11
    cyc(0, '0, 1, 32'h14, 1, 32'h40);
    cyc(0, '0, 1, 32'h14, 1, 32'h40);
    idle(6);
    cyc(1, 32'h14, 0, '0, 0, '0);
    chk("t2_pt",  32'(pred_taken), 32'd1);
    chk("t2_ptg", pred_target,     32'h40);

    // not-taken from 11 -> 10, then -> 00, target kept
    cyc(0, '0, 1, 32'h14, 0, 32'hDEAD);
    idle(4);
    cyc(1, 32'h14, 0, '0, 0, '0);
    chk("nt1_pt",  32'(pred_taken), 32'd1);
    chk("nt1_ptg", pred_target,     32'h40);
    cyc(0, '0, 1, 32'h14, 0, 32'hBEEF);
    idle(4);
    cyc(1, 32'h14, 0, '0, 0, '0);
    chk("nt2_pt",  32'(pred_taken), 32'd0);
    chk("nt2_ptg", pred_target,     32'h40);

    // starvation bound with lk_valid held
    cyc(1, 32'h100, 1, 32'h200, 1, 32'h55);
    for (int i = 0; i < 6; i++) begin
      chk("starve_lk_ready", 32'(lk_ready), 32'(exp_r[i]));
      chk("starve_q_count",  32'(q_count),  32'(exp_q[i]));
      cyc(1, 32'h100, 0, '0, 0, '0);
    end
    idle(2);

    // fill the FIFO while lookups stream
    for (int i = 0; i < 4; i++) cyc(1, 32'h104, 1, 32'h400 + 32'(i * 4), i[0], 32'h1000 + 32'(i));
    chk("full_q_count",  32'(q_count),  32'd4);
    chk("full_up_ready", 32'(up_ready), 32'd0);
    chk("full_lk_ready", 32'(lk_ready), 32'd0);
    cyc(1, 32'h104, 1, 32'h500, 1, 32'h77);
    chk("held_q_count",  32'(q_count),  32'd4);
    chk("held_up_ready", 32'(up_ready), 32'd0);
    cyc(1, 32'h104, 1, 32'h500, 1, 32'h77);
    chk("pop_q_count",   32'(q_count),  32'd3);
    chk("pop_up_ready",  32'(up_ready), 32'd1);
    cyc(1, 32'h104, 1, 32'h500, 1, 32'h77);
    idle(16);

    // reset while in UPD_WR abandons the update
    cyc(0, '0, 1, 32'h18, 1, 32'h99);
    cyc(0, '0, 0, '0, 0, '0);
    chk("wr_lk_ready", 32'(lk_ready), 32'd0);
    chk("wr_q_count",  32'(q_count),  32'd1);
    do_reset();
    cyc(1, 32'h18, 0, '0, 0, '0);
    chk("abandon_pt",  32'(pred_taken), 32'd0);
    chk("abandon_ptg", pred_target,     32'd0);

    // lookup behind a queued update to the same index
    cyc(1, 32'h300, 1, 32'h14, 1, 32'h80);
    cyc(1, 32'h14, 0, '0, 0, '0);
    chk("raw_pv", 32'(pred_valid), 32'd1);
`ifdef BP_SCHED_BYPASS_EN
    chk("raw_pt",  32'(pred_taken), 32'd1);
    chk("raw_ptg", pred_target,     32'h80);
`else
    chk("raw_pt",  32'(pred_taken), 32'd0);
    chk("raw_ptg", pred_target,     32'd0);
`endif
    idle(6);

    // random traffic over a few indices with random upper/lower pc bits
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      r    = $urandom;
      pc_l = (r & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
      r    = $urandom;
      pc_u = (r & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
      cyc($urandom_range(0, 99) < 70, pc_l, $urandom_range(0, 99) < 45, pc_u,
          1'($urandom_range(0, 1)), $urandom);
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bp_sched.md
# bp_sched

Scheduler and arbiter for the branch prediction table shared by the Decode-stage lookup port and the Execute-stage update port. The table is a single-ported 2-bit-counter plus target store with one access per cycle. Resolved-branch updates are buffered in a small FIFO and drained in a two-cycle read-modify-write sequence. Lookups have priority, and a starvation counter bounds how long updates can wait.

## Interface
- ENTRIES, 256, table entries (power of two); index = pc[log2(ENTRIES)+1:2]
- QDEPTH, 4, update FIFO depth (power of two)
- STARVE_MAX, 3, max consecutive granted lookups while FIFO non-empty
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- lk_valid  in  1  Decode has a branch (OP 1100011) needing prediction
- lk_pc  in  32  PC of that branch
- lk_ready  out  1  lookup granted this cycle when lk_valid & lk_ready
- pred_valid  out  1  prediction result valid (one cycle)
- pred_taken  out  1  predicted direction
- pred_target  out  32  predicted target
- up_valid  in  1  Execute resolved a branch
- up_pc  in  32  PC of resolved branch
- up_taken  in  1  actual outcome
- up_target  in  32  actual target (PCTargetE)
- up_ready  out  1  FIFO not full; push when up_valid & up_ready
- q_count  out  log2(QDEPTH)+1  FIFO occupancy

## Operation
- Table entry: 2-bit state plus 32-bit target. Predict taken iff state[1]=1.
- State update on taken: 00→01, 01→11, 10→11, 11→11. Target is written with up_target.
- State update on not-taken: 00→00, 01→00, 10→00, 11→10. Target is unchanged.
- FSM states are IDLE, UPD_RD and UPD_WR.
- In IDLE, `force = (q_count==QDEPTH) | (starve_cnt==STARVE_MAX)`.
- `lk_ready = (state==IDLE) & !force`.
- In IDLE with a granted lookup: read table at lk_pc's index and register the result into pred_*.
- In IDLE with no grant and FIFO non-empty: go to UPD_RD and clear starve_cnt.
- In UPD_RD: read the state of the FIFO head's entry, then go to UPD_WR.
- In UPD_WR: write the next state (and target if taken), pop the FIFO, return to IDLE.
- starve_cnt increments on each granted lookup while the FIFO is non-empty, saturating at STARVE_MAX. It clears on UPD_RD entry and whenever the FIFO is empty.
- FIFO push and pop in the same cycle leave q_count unchanged. up_ready depends only on q_count<QDEPTH, not on a same-cycle pop.
- Read-after-write hazard: a lookup to an index with a queued update returns the stale table value (unless the bypass is enabled, see Configuration).

## Timing
- Lookup granted in cycle N gives pred_valid=1 in N+1 with pred_taken/pred_target.
- pred_valid=0 in every cycle without a preceding grant. pred_taken/pred_target hold their last values.
- Update accepted in cycle N with FIFO empty and no lookup: UPD_RD in N+1, UPD_WR in N+2. The write is visible to a lookup granted in N+3 or later.
- lk_ready=0 during UPD_RD and UPD_WR; each drained update costs exactly 2 lookup cycles.
- Worst-case lookup stall is 2 cycles after STARVE_MAX grants.
- Reset (async assert, sync release) puts:
  - FSM in IDLE; FIFO empty; q_count=0; starve_cnt=0.
  - All table states to 00 and all targets to 0.
  - pred_valid=0, pred_taken=0, pred_target=0.
  - up_ready=1 and lk_ready=1 after release.
- Reset during UPD_RD/UPD_WR abandons the update: no table write, and the FIFO contents are discarded.

## Configuration
- BP_SCHED_BYPASS_EN
  - Defined: on a granted lookup, the youngest FIFO entry matching the lookup index overrides the result. pred_taken=up_taken of that entry; pred_target=its up_target if taken, else the table target.
  - Undefined: no FIFO search; stale table values are returned.

## Test plan
- Lookup 0x14 after reset → next cycle pred_valid=1, pred_taken=0, pred_target=0.
- Two updates {0x14, taken, 0x40} with lk_valid=0, then lookup 0x14 → pred_taken=1, pred_target=0x40 (state 11).
- From state 11, update 0x14 not-taken → lookup gives taken=1 (state 10). A second not-taken update → taken=0 (state 00), target still 0x40.
- STARVE_MAX=3, one queued update, lk_valid held high → lk_ready high 3 cycles, low 2 cycles (UPD_RD, UPD_WR), then high again; q_count goes 1→0 at the UPD_WR edge.
- STARVE_MAX=7, lk_valid held high, 4 updates pushed in 4 cycles starting when starve_cnt=0 → q_count=4, up_ready=0, lk_ready=0 (forced drain); a 5th update is held until the first pop.
- Reset asserted during UPD_WR → no write (lookup to that PC returns taken=0), q_count=0, pred_valid=0. With BP_SCHED_BYPASS_EN: queue {0x14, taken, 0x80}, then immediately look up 0x14 → pred_taken=1, pred_target=0x80.
